// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID pipeline registers: bus widths, the zero word
// and the stall-bus bit that freezes the ID stage.
package if_id_queue_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int StallBus    = 6;
    localparam int StallId     = 1;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/if_id_queue_if.sv
// IF-to-queue fetch handshake plus the queue-to-ID instruction stage.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    // Fetch side is valid/ready: a transfer happens on the rising edge where
    // if_valid and if_ready are both 1; if_ready never depends on if_valid.
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;

    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output if_valid, if_pc, if_inst,
        input  if_ready,
        input  id_valid, id_pc, id_inst
    );

    modport slave (
        input  if_valid, if_pc, if_inst,
        output if_ready,
        output id_valid, id_pc, id_inst
    );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Entry storage for the IF/ID queue: synchronous write, asynchronous read.
// Contents are not reset; the queue pointers decide which entries are live.
module if_id_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID pipeline register with a DEPTH-entry {pc, inst} FIFO ahead of the
// registered ID stage, so fetch can run ahead while ID is stalled.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W    = InstAddrBus,
    parameter int INST_W    = InstBus,
    parameter int DEPTH     = 4,
    parameter int STALL_W   = StallBus,
    parameter int STALL_BIT = StallId
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall_sign,
    input  logic                   flush,
    if_id_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic [ENT_W-1:0]  rd_entry;

    logic              id_valid_q;
    logic [ADDR_W-1:0] id_pc_q;
    logic [INST_W-1:0] id_inst_q;

    logic stall;
    logic empty;
    logic ready;
    logic push;
    logic pop;
    logic bypass;
    logic wr_en;

    logic unused_stall_bits;
    assign unused_stall_bits = ^stall_sign;

    assign stall = stall_sign[STALL_BIT];
    assign empty = (cnt_q == '0);
    assign ready = (cnt_q != FULL_CNT);
    assign push  = bus.if_valid && ready;

    // An empty queue with a free output stage forwards the fetch directly,
    // so the entry never touches storage and latency stays at one cycle.
    assign pop    = !flush && !stall && !empty;
    assign bypass = !flush && !stall && empty && push;
    assign wr_en  = push && !flush && !bypass;

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({bus.if_pc, bus.if_inst}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= ADDR_W'(ZeroWord);
            id_inst_q  <= INST_W'(ZeroWord);
        end else if (flush) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= ADDR_W'(ZeroWord);
            id_inst_q  <= INST_W'(ZeroWord);
        end else if (!stall) begin
            if (pop) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= rd_entry[ENT_W-1:INST_W];
                id_inst_q  <= rd_entry[INST_W-1:0];
            end else if (bypass) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= bus.if_pc;
                id_inst_q  <= bus.if_inst;
            end else begin
                id_valid_q <= 1'b0;
                id_pc_q    <= ADDR_W'(ZeroWord);
                id_inst_q  <= INST_W'(ZeroWord);
            end
        end
    end

    assign bus.if_ready = ready;
    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign count        = cnt_q;

endmodule
